mem_inst_loader: RTL and testbench
==================================

# mem_inst_loader

Program loader that writes instruction memory. Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit MIPS instruction words, and issues one write per word to the instruction memory write port at consecutive word addresses. Holds the single-cycle CPU (PC) in stall until the image is completely written, then releases it. Sits between the host/serial byte source and the instruction memory, ahead of the CPU's instruction fetch path.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written (must be word-aligned)
- MAX_WORDS, 256, largest accepted word count; larger headers are rejected
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR, ignored otherwise
- in_valid  in  1  byte source has in_data valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  one-cycle instruction memory write strobe
- wr_addr  out  32  byte address of the write, BASE_ADDR + 4*index
- wr_data  out  32  assembled instruction word
- cpu_hold  out  1  1 = CPU/PC stalled; 0 = CPU may fetch
- done  out  1  image loaded successfully
- err  out  1  load aborted

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N payload bytes, each word MSB-first (first byte -> wr_data[31:24]).
- Byte accepted only when in_valid & in_ready on a rising edge; in_data is ignored otherwise.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK (only with macro), DONE, ERR.
- IDLE: in_ready=0; start -> LEN_HI, clears done/err, word index, byte counter.
- LEN_HI / LEN_LO: in_ready=1; capture count bytes. After LEN_LO: N=0 -> DONE (or CHK); N>MAX_WORDS -> ERR; else -> DATA.
- DATA: in_ready=1; 2-bit byte counter shifts bytes into a word register. Acceptance of the 4th byte sets wr_en=1 on the following cycle with wr_data = assembled word, wr_addr = BASE_ADDR + 4*index; index increments. After the Nth word -> DONE (or CHK).
- DONE: in_ready=0, cpu_hold=0, done=1. start -> LEN_HI, cpu_hold=1 from the next cycle.
- ERR: in_ready=0, cpu_hold=1, err=1. start -> LEN_HI. Words already written stay written; no rollback.
- start while in LEN_HI/LEN_LO/DATA/CHK: ignored.
- Address arithmetic 32-bit, wraps modulo 2^32 (not reachable with legal parameters).

## Timing
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, err=0.
- rst_n low mid-load: immediate return to reset values; partial word discarded; cpu_hold asserts asynchronously.
- All outputs registered; in_ready is a function of registered state only.
- Full throughput: one byte per cycle when in_valid held high; N-word image loads in 2+4N accepted bytes.
- wr_en pulses exactly one cycle, one cycle after the 4th byte of a word; never two consecutive cycles (min 4 cycles apart).
- done/cpu_hold change on the edge following the last accepted byte (last wr_en and cpu_hold=0 occur in the same cycle).
- in_valid gaps of any length stall assembly without loss; byte counter holds.

## Configuration
- MEM_INST_LOADER_CHECKSUM_EN defined: after the last payload byte (or after LEN_LO if N=0) enter CHK; one trailer byte accepted; it must equal the XOR of LEN_HI, LEN_LO and all payload bytes. Match -> DONE; mismatch -> ERR.
- Not defined: no CHK state, no trailer byte; err set only by N>MAX_WORDS.

## Test plan
- Reset then start, stream 00 01 20 08 00 05 -> wr_en one cycle, wr_addr=0x0, wr_data=0x20080005; then done=1, cpu_hold=0, in_ready=0.
- N=3 with in_valid toggled every other cycle -> writes at 0x0, 0x4, 0x8 in order with correct words, no extra wr_en.
- Header 01 01 (N=257, MAX_WORDS=256) -> err=1, cpu_hold=1, no wr_en; start then valid 1-word image -> done=1.
- rst_n low after 2 payload bytes of word 1 -> all outputs at reset values immediately; no write of partial word; new load from start works.
- Header 00 00 -> done=1 without any wr_en (with macro: trailer 0x00 required; 0x00 -> done, 0x01 -> err).
- With macro: 00 01 AA BB CC DD + trailer 0x01 (XOR) -> done=1; trailer 0x02 -> err=1, word at 0x0 still written.

Source files
------------

// File: rtl/mem_inst_loader.sv
// Program loader: assembles big-endian 32-bit words from a byte stream and writes them to instruction memory.
// Define MEM_INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module mem_inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  output logic        o_in_ready,
  output logic        o_wr_en,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_err
);

  // state  | meaning
  // IDLE   | after reset, waiting for start
  // LEN_HI | expecting word-count high byte
  // LEN_LO | expecting word-count low byte
  // DATA   | assembling payload words
  // CHK    | expecting XOR trailer byte (checksum build only)
  // DONE   | image loaded, CPU released
  // ERR    | load aborted, CPU held
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
`ifdef MEM_INST_LOADER_CHECKSUM_EN
    , S_CHK  = 3'd6
`endif
  } state_t;

`ifdef MEM_INST_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [15:0] r_idx;
  logic [1:0]  r_bcnt;
  logic [23:0] r_word;

  logic        w_acc;
  logic        w_start_ok;
  logic        w_last_byte;
  logic [15:0] w_len;
  logic        w_in_ready_nxt;
  logic        w_wr_en_nxt;
  logic        w_hold_nxt;
  logic        w_done_nxt;
  logic        w_err_nxt;

  assign w_acc       = i_in_valid & o_in_ready;
  assign w_len       = {r_len_hi, i_in_data};
  assign w_last_byte = (r_bcnt == 2'd3) && ((r_idx + 16'd1) == r_len);
  assign w_start_ok  = i_start &&
                       ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

`ifdef MEM_INST_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csum <= 8'h00;
    end else if (w_start_ok) begin
      r_csum <= 8'h00;
    end else if (w_acc && (r_state != S_CHK)) begin
      r_csum <= r_csum ^ i_in_data;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_start) w_state_nxt = S_LEN_HI;
      S_LEN_HI: if (w_acc) w_state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (w_acc) begin
          if (w_len == 16'd0)               w_state_nxt = S_FIN;
          else if ({1'b0, w_len} > MAX_W)   w_state_nxt = S_ERR;
          else                              w_state_nxt = S_DATA;
        end
      end
      S_DATA: if (w_acc && w_last_byte) w_state_nxt = S_FIN;
`ifdef MEM_INST_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_acc) w_state_nxt = (i_in_data == r_csum) ? S_DONE : S_ERR;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    w_in_ready_nxt = (w_state_nxt == S_LEN_HI) || (w_state_nxt == S_LEN_LO) ||
                     (w_state_nxt == S_DATA)
`ifdef MEM_INST_LOADER_CHECKSUM_EN
                     || (w_state_nxt == S_CHK)
`endif
                     ;
    w_hold_nxt  = (w_state_nxt != S_DONE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_err_nxt   = (w_state_nxt == S_ERR);
    w_wr_en_nxt = (r_state == S_DATA) && w_acc && (r_bcnt == 2'd3);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_in_ready <= 1'b0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= BASE_ADDR;
      o_wr_data  <= 32'h0;
      o_cpu_hold <= 1'b1;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_in_ready <= w_in_ready_nxt;
      o_wr_en    <= w_wr_en_nxt;
      o_cpu_hold <= w_hold_nxt;
      o_done     <= w_done_nxt;
      o_err      <= w_err_nxt;
      if (w_wr_en_nxt) begin
        o_wr_data <= {r_word, i_in_data};
        o_wr_addr <= BASE_ADDR + {14'd0, r_idx, 2'b00};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len_hi <= 8'h00;
      r_len    <= 16'h0;
      r_idx    <= 16'h0;
      r_bcnt   <= 2'd0;
      r_word   <= 24'h0;
    end else if (w_start_ok) begin
      r_idx  <= 16'h0;
      r_bcnt <= 2'd0;
    end else if (w_acc) begin
      unique case (r_state)
        S_LEN_HI: r_len_hi <= i_in_data;
        S_LEN_LO: r_len    <= w_len;
        S_DATA: begin
          r_word <= {r_word[15:0], i_in_data};
          r_bcnt <= r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) r_idx <= r_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_inst_loader.sv
// Randomized self-checking bench for mem_inst_loader against a stream-level reference model.
module tb_mem_inst_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 256;
`ifdef MEM_INST_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wr_en, cpu_hold, done, err;
  logic [31:0] wr_addr, wr_data;

  always #5 clk = ~clk;

  mem_inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_in_ready(in_ready), .o_wr_en(wr_en),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_cpu_hold(cpu_hold),
    .o_done(done), .o_err(err)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [63:0] got_q[$];
  logic        hold_q[$];
  logic        prev_wr_en = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      check("wr_en_back_to_back", prev_wr_en, 0);
      got_q.push_back({wr_addr, wr_data});
      hold_q.push_back(cpu_hold);
    end
    prev_wr_en = wr_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Stream: count header, payload words MSB-first, then XOR trailer when checksums are enabled.
  function automatic void build(input int n_hdr, input logic [31:0] words[$], input bit bad_trl,
                                output logic [7:0] s[$]);
    logic [7:0] x;
    s = {};
    s.push_back(8'((n_hdr >> 8) & 255));
    s.push_back(8'(n_hdr & 255));
    if (n_hdr <= MAXW) begin
      foreach (words[i]) begin
        s.push_back(words[i][31:24]); s.push_back(words[i][23:16]);
        s.push_back(words[i][15:8]);  s.push_back(words[i][7:0]);
      end
      if (CSUM) begin
        x = 8'h00;
        foreach (s[i]) x = x ^ s[i];
        s.push_back(bad_trl ? (x ^ 8'h01) : x);
      end
    end
  endfunction

  function automatic void model(input logic [7:0] s[$], output logic [63:0] w[$],
                                output bit e_done, output bit e_err);
    int n;
    logic [7:0] x;
    w = {};
    n = s[0] * 256 + s[1];
    e_done = 1'b0;
    e_err = 1'b0;
    if (n > MAXW) begin
      e_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++)
      w.push_back({BASE + 32'(4 * i), s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
    if (CSUM) begin
      x = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) x = x ^ s[i];
      e_done = (s[2+4*n] == x);
      e_err  = !e_done;
    end else begin
      e_done = 1'b1;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax, input bit pulse);
    int g, w;
    g = $urandom_range(gmax, gmin);
    repeat (g) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    start = pulse;
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      start = 1'b0;
      w++;
    end
    if (w >= 40) check("in_ready_timeout", 1, 0);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input string nm, input logic [7:0] s[$], input int gmin,
                          input int gmax, input int start_at);
    logic [63:0] ew[$];
    bit ed, ee;
    int w, n;
    got_q.delete();
    hold_q.delete();
    pulse_start();
    foreach (s[i]) send_byte(s[i], gmin, gmax, i == start_at);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!(done || err) && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check({nm, "_finish_timeout"}, 1, 0);
    @(negedge clk);
    model(s, ew, ed, ee);
    n = ew.size();
    check({nm, "_nwrites"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check({nm, "_write"}, got_q[i], ew[i]);
      check({nm, "_hold_at_write"}, hold_q[i], !(i == n - 1 && !CSUM && ed));
    end
    check({nm, "_done"}, done, ed);
    check({nm, "_err"}, err, ee);
    check({nm, "_hold"}, cpu_hold, !ed);
    check({nm, "_in_ready"}, in_ready, 0);
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_in_ready"}, in_ready, 0);
    check({nm, "_wr_en"}, wr_en, 0);
    check({nm, "_wr_addr"}, wr_addr, BASE);
    check({nm, "_wr_data"}, wr_data, 0);
    check({nm, "_hold"}, cpu_hold, 1);
    check({nm, "_done"}, done, 0);
    check({nm, "_err"}, err, 0);
  endtask

  initial begin
    logic [7:0]  s[$];
    logic [31:0] wq[$];
    int n;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle");

    wq = '{32'h2008_0005};
    build(1, wq, 1'b0, s);
    run_load("single", s, 0, 0, -1);

    wq = '{$urandom, $urandom, $urandom};
    build(3, wq, 1'b0, s);
    run_load("gapped", s, 1, 1, -1);

    wq = {};
    build(257, wq, 1'b0, s);
    run_load("too_long", s, 0, 0, -1);

    wq = '{32'hDEAD_BEEF};
    build(1, wq, 1'b0, s);
    run_load("after_err", s, 0, 2, -1);

    wq = {};
    build(0, wq, 1'b0, s);
    run_load("empty", s, 0, 0, -1);

    if (CSUM) begin
      wq = '{32'hAABB_CCDD};
      build(1, wq, 1'b1, s);
      run_load("bad_trailer", s, 0, 0, -1);
      wq = {};
      build(0, wq, 1'b1, s);
      run_load("empty_bad_trailer", s, 0, 0, -1);
    end

    // Reset after two payload bytes of the first word.
    got_q.delete();
    pulse_start();
    send_byte(8'h00, 0, 0, 1'b0);
    send_byte(8'h02, 0, 0, 1'b0);
    send_byte(8'h12, 0, 0, 1'b0);
    send_byte(8'h34, 0, 0, 1'b0);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1 check_reset_values("async_reset");
    check("async_reset_no_write", got_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wq = '{$urandom, $urandom};
    build(2, wq, 1'b0, s);
    run_load("after_reset", s, 0, 1, 3);

    wq = {};
    for (int i = 0; i < MAXW; i++) wq.push_back($urandom);
    build(MAXW, wq, 1'b0, s);
    run_load("max_words", s, 0, 0, -1);

    for (int it = 0; it < 10; it++) begin
      wq = {};
      n = $urandom_range(6, 1);
      if (it == 3) n = 0;
      if (it == 6) n = MAXW + 1 + $urandom_range(40, 0);
      if (n <= MAXW) for (int i = 0; i < n; i++) wq.push_back($urandom);
      build(n, wq, 1'($urandom_range(1, 0)), s);
      run_load("random", s, 0, 3, $urandom_range(s.size() + 2, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
